// File: rtl/audio_pcm_scheduler.sv
// Sample-rate pacer and two-source arbiter feeding audio_stereo_out in the clk_pcm domain.
// One stereo sample per SAMPLE_DIV clocks; silence is substituted when no source is ready.
module audio_pcm_scheduler #(
  parameter int W          = 8,
  parameter int SAMPLE_DIV = 1134,
  parameter bit ARB_RR     = 1'b1,
  parameter int SILENCE    = 0
) (
  input  logic           clk_pcm,
  input  logic           aclr_n,
  input  logic           enable,
  input  logic           clear_stats,
  input  logic           src0_valid,
  output logic           src0_ready,
  input  logic [2*W-1:0] src0_pcm,
  input  logic           src1_valid,
  output logic           src1_ready,
  input  logic [2*W-1:0] src1_pcm,
  output logic           stereo_pcm_rdy,
  output logic [2*W-1:0] stereo_pcm,
  input  logic           fifo_full,
  output logic           grant_src,
  output logic [15:0]    underrun_cnt,
  output logic [15:0]    overrun_cnt
);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0]  TICK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [W-1:0]   SIL_CH    = W'(SILENCE);
  localparam logic [2*W-1:0] SIL_WORD  = {SIL_CH, SIL_CH};

  typedef enum logic [1:0] {IDLE, WAIT_TICK, FETCH, PUSH} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  tick_cnt;
  logic [2*W-1:0] sample_reg;
  logic           tick, any_valid, both_valid, pick;
  logic           grant_sel, grant_both, rr_ptr, push;
  logic           take_tick, underrun_inc, overrun_inc;

  assign tick       = (state != IDLE) && (tick_cnt == TICK_LAST);
  assign any_valid  = src0_valid | src1_valid;
  assign both_valid = src0_valid & src1_valid;
  // With a single requester the grant simply follows src1_valid.
  assign pick       = both_valid ? (ARB_RR ? rr_ptr : 1'b0) : src1_valid;

  assign take_tick    = (state == WAIT_TICK) && enable && tick;
  assign underrun_inc = take_tick && !any_valid;
  assign overrun_inc  = (state == PUSH) && fifo_full && tick;

  always_ff @(posedge clk_pcm or negedge aclr_n) begin
    if (!aclr_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE:      if (enable) state_nxt = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable)         state_nxt = IDLE;
        else if (tick)       state_nxt = any_valid ? FETCH : PUSH;
      end
      FETCH: begin
        src0_ready = !grant_sel;
        src1_ready = grant_sel;
        state_nxt  = PUSH;
      end
      PUSH: begin
        if (!fifo_full) begin
          push      = 1'b1;
          state_nxt = WAIT_TICK;
        end
      end
      default:             state_nxt = IDLE;
    endcase
  end

  // Pacing counter free-runs outside IDLE so blocked pushes do not shift the sample grid.
  always_ff @(posedge clk_pcm or negedge aclr_n) begin
    if (!aclr_n)              tick_cnt <= '0;
    else if (state == IDLE)   tick_cnt <= '0;
    else if (tick)            tick_cnt <= '0;
    else                      tick_cnt <= tick_cnt + CW'(1);
  end

  always_ff @(posedge clk_pcm or negedge aclr_n) begin
    if (!aclr_n) begin
      sample_reg     <= SIL_WORD;
      stereo_pcm     <= '0;
      stereo_pcm_rdy <= 1'b0;
      grant_src      <= 1'b0;
      grant_sel      <= 1'b0;
      grant_both     <= 1'b0;
      rr_ptr         <= 1'b0;
    end else begin
      stereo_pcm_rdy <= push;
      if (push) stereo_pcm <= sample_reg;
      if (take_tick) begin
        if (any_valid) begin
          grant_sel  <= pick;
          grant_both <= both_valid;
        end else begin
          sample_reg <= SIL_WORD;
        end
      end
      if (state == FETCH) begin
        sample_reg <= grant_sel ? src1_pcm : src0_pcm;
        grant_src  <= grant_sel;
        if (grant_both) rr_ptr <= ~grant_sel;
      end
    end
  end

  // Clear wins over a coincident increment; both counters stick at all-ones.
  always_ff @(posedge clk_pcm or negedge aclr_n) begin
    if (!aclr_n) begin
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else if (clear_stats) begin
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      if (underrun_inc && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      if (overrun_inc  && overrun_cnt  != 16'hFFFF) overrun_cnt  <= overrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_audio_pcm_scheduler.sv
// Bench for audio_pcm_scheduler: directed scenarios plus randomized traffic checked
// against a tick-level transaction model of arbitration, silence and pacing.
module tb_audio_pcm_scheduler;
  localparam int W   = 8;
  localparam int DIV = 8;

  logic           clk_pcm = 1'b0;
  logic           aclr_n = 1'b0, enable = 1'b0, clear_stats = 1'b0, fifo_full = 1'b0;
  logic           src0_valid = 1'b0, src1_valid = 1'b0;
  logic [2*W-1:0] src0_pcm = '0, src1_pcm = '0;
  logic           src0_ready, src1_ready, stereo_pcm_rdy, grant_src;
  logic [2*W-1:0] stereo_pcm;
  logic [15:0]    underrun_cnt, overrun_cnt;
  logic           fp_src0_ready, fp_src1_ready, fp_rdy, fp_grant;
  logic [2*W-1:0] fp_pcm;
  logic [15:0]    fp_ucnt, fp_ocnt;

  int passed = 0;
  int total  = 0;

  always #5 clk_pcm = ~clk_pcm;

  audio_pcm_scheduler #(.W(W), .SAMPLE_DIV(DIV), .ARB_RR(1'b1), .SILENCE(0)) dut (
    .clk_pcm(clk_pcm), .aclr_n(aclr_n), .enable(enable), .clear_stats(clear_stats),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_pcm(src0_pcm),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_pcm(src1_pcm),
    .stereo_pcm_rdy(stereo_pcm_rdy), .stereo_pcm(stereo_pcm), .fifo_full(fifo_full),
    .grant_src(grant_src), .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt));

  audio_pcm_scheduler #(.W(W), .SAMPLE_DIV(DIV), .ARB_RR(1'b0), .SILENCE(0)) dut_fp (
    .clk_pcm(clk_pcm), .aclr_n(aclr_n), .enable(enable), .clear_stats(clear_stats),
    .src0_valid(src0_valid), .src0_ready(fp_src0_ready), .src0_pcm(src0_pcm),
    .src1_valid(src1_valid), .src1_ready(fp_src1_ready), .src1_pcm(src1_pcm),
    .stereo_pcm_rdy(fp_rdy), .stereo_pcm(fp_pcm), .fifo_full(fifo_full),
    .grant_src(fp_grant), .underrun_cnt(fp_ucnt), .overrun_cnt(fp_ocnt));

  task automatic cyc();
    @(posedge clk_pcm);
    #1;
  endtask

  // Leaves the DUT in IDLE, one cycle after reset release; caller's next drive is cycle 0.
  task automatic do_reset();
    aclr_n = 1'b0; enable = 1'b0; clear_stats = 1'b0; fifo_full = 1'b0;
    src0_valid = 1'b0; src1_valid = 1'b0; src0_pcm = '0; src1_pcm = '0;
    repeat (2) cyc();
    aclr_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; enable = 1'b1; src0_valid = 1'b1; src1_valid = 1'b1;
    repeat (2) cyc();
    total++;
    if ({src0_ready, src1_ready, stereo_pcm_rdy, grant_src} !== 4'b0000)
      $display("FAIL reset_ctrl got %b want 0000", {src0_ready, src1_ready, stereo_pcm_rdy, grant_src});
    else passed++;
    total++;
    if ({stereo_pcm, underrun_cnt, overrun_cnt} !== 48'h0)
      $display("FAIL reset_data got %h want 0", {stereo_pcm, underrun_cnt, overrun_cnt});
    else passed++;
  endtask

  task automatic test_single_source();
    logic [2:0] e;
    do_reset();
    src0_valid = 1'b1; src0_pcm = 16'h7F00; enable = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      cyc();
      e = {(c >= DIV && c % DIV == 1), 1'b0, (c >= DIV && c % DIV == 3)};
      total++;
      if ({src0_ready, src1_ready, stereo_pcm_rdy} !== e)
        $display("FAIL single_hs c=%0d got %b want %b", c, {src0_ready, src1_ready, stereo_pcm_rdy}, e);
      else passed++;
      if (e[0]) begin
        total++;
        if ({stereo_pcm, grant_src} !== {16'h7F00, 1'b0})
          $display("FAIL single_data c=%0d got %h/%b want 7f00/0", c, stereo_pcm, grant_src);
        else passed++;
      end
    end
    total++;
    if ({underrun_cnt, overrun_cnt} !== 32'h0)
      $display("FAIL single_cnt got %h want 0", {underrun_cnt, overrun_cnt});
    else passed++;
  endtask

  task automatic test_arbitration();
    logic [5:0]  e;
    logic [15:0] rr_data;
    int k;
    do_reset();
    src0_valid = 1'b1; src0_pcm = 16'h7F00; src1_valid = 1'b1; src1_pcm = 16'h007F; enable = 1'b1;
    for (int c = 1; c <= 6 * DIV + 3; c++) begin
      cyc();
      k = c / DIV;
      e = {(k >= 1 && c % DIV == 1 && k % 2 == 1), (k >= 1 && c % DIV == 1 && k % 2 == 0),
           (k >= 1 && c % DIV == 3),
           (k >= 1 && c % DIV == 1), 1'b0, (k >= 1 && c % DIV == 3)};
      total++;
      if ({src0_ready, src1_ready, stereo_pcm_rdy, fp_src0_ready, fp_src1_ready, fp_rdy} !== e)
        $display("FAIL arb_hs c=%0d got %b want %b", c,
                 {src0_ready, src1_ready, stereo_pcm_rdy, fp_src0_ready, fp_src1_ready, fp_rdy}, e);
      else passed++;
      if (e[3]) begin
        rr_data = (k % 2 == 1) ? 16'h7F00 : 16'h007F;
        total++;
        if ({stereo_pcm, grant_src, fp_pcm, fp_grant} !== {rr_data, (k % 2 == 0), 16'h7F00, 1'b0})
          $display("FAIL arb_data c=%0d got rr %h/%b fp %h/%b want rr %h fp 7f00", c,
                   stereo_pcm, grant_src, fp_pcm, fp_grant, rr_data);
        else passed++;
      end
    end
  endtask

  task automatic test_underrun();
    logic [2:0]  e;
    logic [15:0] d;
    do_reset();
    src0_valid = 1'b1; src0_pcm = 16'h7F00; enable = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      cyc();
      e = {(c == 9), 1'b0, (c == 11 || c == 18 || c == 26 || c == 34)};
      total++;
      if ({src0_ready, src1_ready, stereo_pcm_rdy} !== e)
        $display("FAIL underrun_hs c=%0d got %b want %b", c, {src0_ready, src1_ready, stereo_pcm_rdy}, e);
      else passed++;
      if (e[0]) begin
        d = (c == 11) ? 16'h7F00 : 16'h0000;
        total++;
        if (stereo_pcm !== d) $display("FAIL underrun_data c=%0d got %h want %h", c, stereo_pcm, d);
        else passed++;
      end
      if (c == 10) src0_valid = 1'b0;
    end
    total++;
    if (underrun_cnt !== 16'd3) $display("FAIL underrun_cnt got %0d want 3", underrun_cnt);
    else passed++;
  endtask

  task automatic test_fifo_full();
    logic [2:0]  e;
    logic [15:0] d;
    do_reset();
    src0_valid = 1'b1; src0_pcm = 16'h1234; enable = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      cyc();
      e = {(c == 9 || c == 33), 1'b0, (c == 30 || c == 35)};
      total++;
      if ({src0_ready, src1_ready, stereo_pcm_rdy} !== e)
        $display("FAIL full_hs c=%0d got %b want %b", c, {src0_ready, src1_ready, stereo_pcm_rdy}, e);
      else passed++;
      if (e[0]) begin
        d = (c == 30) ? 16'h1234 : 16'h5678;
        total++;
        if (stereo_pcm !== d) $display("FAIL full_data c=%0d got %h want %h", c, stereo_pcm, d);
        else passed++;
      end
      if (c == 9)  fifo_full = 1'b1;
      if (c == 10) src0_pcm = 16'h5678;
      if (c == 29) fifo_full = 1'b0;
    end
    total++;
    if ({overrun_cnt, underrun_cnt} !== {16'd2, 16'd0})
      $display("FAIL full_cnt got ovr %0d und %0d want 2 0", overrun_cnt, underrun_cnt);
    else passed++;
  endtask

  task automatic test_enable_drop();
    logic [2:0] e;
    do_reset();
    src0_valid = 1'b1; src0_pcm = 16'hAB01; enable = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      cyc();
      e = {(c == 9 || c == 34), 1'b0, (c == 11 || c == 36)};
      total++;
      if ({src0_ready, src1_ready, stereo_pcm_rdy} !== e)
        $display("FAIL endrop_hs c=%0d got %b want %b", c, {src0_ready, src1_ready, stereo_pcm_rdy}, e);
      else passed++;
      if (c == 11) begin
        total++;
        if (stereo_pcm !== 16'hAB01) $display("FAIL endrop_data got %h want ab01", stereo_pcm);
        else passed++;
      end
      if (c == 10) enable = 1'b0;
      if (c == 25) enable = 1'b1;
    end
  endtask

  task automatic test_reset_mid_push();
    do_reset();
    src1_valid = 1'b1; src1_pcm = 16'h4242; enable = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      if (c == 9) fifo_full = 1'b1;
    end
    total++;
    if ({grant_src, stereo_pcm_rdy} !== 2'b10)
      $display("FAIL midpush_pre got %b want 10", {grant_src, stereo_pcm_rdy});
    else passed++;
    aclr_n = 1'b0;
    #1;
    total++;
    if ({src0_ready, src1_ready, stereo_pcm_rdy, grant_src, stereo_pcm} !== 20'h0)
      $display("FAIL midpush_rst got %h want 0", {src0_ready, src1_ready, stereo_pcm_rdy, grant_src, stereo_pcm});
    else passed++;
    cyc();
    fifo_full = 1'b0; aclr_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      total++;
      if ({src0_ready, src1_ready, stereo_pcm_rdy} !== {1'b0, (c == 9), 1'b0})
        $display("FAIL midpush_post c=%0d got %b", c, {src0_ready, src1_ready, stereo_pcm_rdy});
      else passed++;
    end
  endtask

  task automatic test_clear_stats();
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      cyc();
      if (c == 23) begin
        total++;
        if (underrun_cnt !== 16'd2) $display("FAIL clear_pre got %0d want 2", underrun_cnt);
        else passed++;
      end
      if (c == 25) begin
        total++;
        if (underrun_cnt !== 16'd0) $display("FAIL clear_coincident got %0d want 0", underrun_cnt);
        else passed++;
      end
      if (c == 33) begin
        total++;
        if (underrun_cnt !== 16'd1) $display("FAIL clear_post got %0d want 1", underrun_cnt);
        else passed++;
      end
      clear_stats = (c == 24);
    end
  endtask

  // Transaction model: at each tick the pending sources are arbitrated by rule,
  // giving the expected ready phase, strobe phase and pushed word.
  task automatic test_random_traffic();
    logic        p0, p1, rr, g, exp_grant;
    logic [15:0] d0, d1, exp_data;
    logic [2:0]  e;
    int kind, under_exp, p;
    do_reset();
    p0 = 1'b0; p1 = 1'b0; rr = 1'b0; g = 1'b0; exp_grant = 1'b0;
    d0 = '0; d1 = '0; exp_data = '0; kind = 0; under_exp = 0;
    enable = 1'b1;
    for (int c = 1; c <= 40 * DIV + 3; c++) begin
      cyc();
      p = c % DIV;
      if (p == 0) begin
        if (!p0 && !p1) begin
          kind = 1; exp_data = 16'h0000; under_exp++;
        end else begin
          g = (p0 && p1) ? rr : p1;
          if (p0 && p1) rr = ~g;
          kind = g ? 3 : 2;
          exp_data = g ? d1 : d0;
          exp_grant = g;
        end
      end
      e = {(p == 1 && kind == 2), (p == 1 && kind == 3), ((p == 2 && kind == 1) || (p == 3 && kind >= 2))};
      total++;
      if ({src0_ready, src1_ready, stereo_pcm_rdy} !== e)
        $display("FAIL rand_hs c=%0d got %b want %b", c, {src0_ready, src1_ready, stereo_pcm_rdy}, e);
      else passed++;
      if (e[0]) begin
        total++;
        if ({stereo_pcm, grant_src} !== {exp_data, exp_grant})
          $display("FAIL rand_data c=%0d got %h/%b want %h/%b", c, stereo_pcm, grant_src, exp_data, exp_grant);
        else passed++;
      end
      if (p == 2 && kind == 2) p0 = 1'b0;
      if (p == 2 && kind == 3) p1 = 1'b0;
      if (p == 4) begin
        if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; d0 = 16'($urandom); end
        if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1'b1; d1 = 16'($urandom); end
      end
      src0_valid = p0; src0_pcm = d0; src1_valid = p1; src1_pcm = d1;
    end
    total++;
    if ({underrun_cnt, overrun_cnt} !== {16'(under_exp), 16'd0})
      $display("FAIL rand_cnt got und %0d ovr %0d want %0d 0", underrun_cnt, overrun_cnt, under_exp);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_arbitration();
    test_underrun();
    test_fifo_full();
    test_enable_drop();
    test_reset_mid_push();
    test_clear_stats();
    test_random_traffic();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
